mips_alu_sequencer: RTL
=======================

// Module: mips_alu_sequencer
// PURPOSE
//  Issue side of the MIPS ALU interface. Accepts decoded instruction fields over valid/ready.
//  Maps opcode/funct to the 4-bit ALU control code and builds operands A/B (immediates extended).
//  Drives the combinational MIPSALU, holds inputs stable ALU_LAT cycles, then samples ALUOut/Zero.
//  Returns result and branch outcome over a second valid/ready channel. Sits between decode and writeback.
// PARAMETERS
//  ALU_LAT  1  cycles operands are held before sampling alu_out/alu_zero; legal range 1..15
// PORTS
//  clock        in   1   system clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  op_valid     in   1   instruction fields valid
//  op_ready     out  1   sequencer can accept
//  opcode       in   6   MIPS opcode
//  funct        in   6   MIPS funct (used when opcode==0)
//  rs_val       in   32  rs register value
//  rt_val       in   32  rt register value
//  imm          in   16  I-type immediate
//  alu_ctl      out  4   to ALU ALUctl
//  alu_a        out  32  to ALU A
//  alu_b        out  32  to ALU B
//  alu_out      in   32  from ALU ALUOut
//  alu_zero     in   1   from ALU Zero
//  res_valid    out  1   result valid
//  res_ready    in   1   consumer accepts result
//  res_data     out  32  sampled ALU result (0 when illegal)
//  res_taken    out  1   branch taken (beq: Zero; bne: !Zero; else 0)
//  res_illegal  out  1   unsupported opcode/funct
// BEHAVIOUR
//  Reset: state=IDLE; op_ready=1; res_valid/res_taken/res_illegal=0; res_data/alu_a/alu_b=0; alu_ctl=0.
//  Reset mid-operation: in-flight op discarded, outputs take reset values immediately (async).
//  Decode (R-type, opcode 0): funct 0x24 AND->0, 0x25 OR->1, 0x20 ADD->2, 0x22 SUB->6, 0x2A SLT->7, 0x27 NOR->12; A=rs, B=rt.
//  Decode (I-type): 0x08 ADDI->2 sign-ext; 0x0A SLTI->7 sign-ext; 0x0C ANDI->0 zero-ext; 0x0D ORI->1 zero-ext;
//   0x04 BEQ->6, 0x05 BNE->6 with B=rt. A=rs in all cases. Anything else: illegal.
//  FSM: IDLE --(op_valid&op_ready, legal)--> EXEC; --(illegal)--> RESP with res_illegal=1, res_data=0.
//   EXEC: alu_ctl/alu_a/alu_b registered, stable; 4-bit counter runs ALU_LAT cycles; on last cycle capture
//   alu_out->res_data, branch result->res_taken; -> RESP.
//   RESP: res_valid=1; res_data/res_taken/res_illegal stable until res_valid&res_ready; then -> IDLE.
//  op_ready=1 only in IDLE (see CONFIGURATION). Input fields sampled only on the accept edge.
//  Latency: accept edge T -> res_valid high in cycle T+ALU_LAT+1 (legal); T+1 (illegal).
//  alu_ctl/alu_a/alu_b hold last issued values outside EXEC (no glitching of ALU inputs).
//  Counter wrap: not possible; counter reloads on each EXEC entry. res_taken=0 for non-branches.
// CONFIGURATION
//  ALU_SEQ_BYPASS_EN defined: op_ready also high in RESP when res_ready=1; a handshake on both channels
//   in one cycle retires the result and goes straight to EXEC (or RESP if illegal). Throughput 1 op / ALU_LAT+1.
//  Not defined: op_ready only in IDLE; one bubble per op; throughput 1 op / ALU_LAT+2.
// TESTING  (bench uses full behavioural ALU model for all six codes)
//  Reset: reset_n low 3 cycles then high -> op_ready=1, res_valid=0, alu_ctl=0.
//  OR: opcode 0 funct 0x25 rs=0x0000F0F0 rt=0x00FF0000 -> alu_ctl=1, res_data=0x00FFF0F0, res_valid at T+ALU_LAT+1.
//  SLTI: opcode 0x0A rs=5 imm=0x0007 -> alu_ctl=7, alu_b=7, res_data=1; ADDI imm=0xFFFF -> alu_b=0xFFFFFFFF.
//  Branch: BEQ rs=rt=0x1234 -> alu_ctl=6, res_taken=1; BNE same operands -> res_taken=0.
//  Illegal: opcode 0 funct 0x03 -> res_illegal=1, res_data=0, res_valid at T+1, no EXEC.
//  Stall/reset: res_ready low 3 cycles -> res_* stable, op_ready=0 (both configs); reset_n low in EXEC -> res_valid=0, op_ready=1 at once.

Source files
------------

// File: rtl/mips_alu_sequencer.sv
// Issue side of the MIPS ALU: decodes fields, holds ALU inputs ALU_LAT cycles, returns result/branch outcome.
// Optional ALU_SEQ_BYPASS_EN: accept the next op in the same cycle the current result is retired.
module mips_alu_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_taken,
  output logic        res_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        br_eq;
  logic        br_ne;

  logic        dec_legal;
  logic [3:0]  dec_ctl;
  logic [31:0] dec_b;
  logic        dec_beq;
  logic        dec_bne;
  logic        accept;

  always_comb begin
    dec_legal = 1'b1;
    dec_ctl   = 4'd0;
    dec_b     = rt_val;
    dec_beq   = 1'b0;
    dec_bne   = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h24:   dec_ctl = 4'd0;
          6'h25:   dec_ctl = 4'd1;
          6'h20:   dec_ctl = 4'd2;
          6'h22:   dec_ctl = 4'd6;
          6'h2A:   dec_ctl = 4'd7;
          6'h27:   dec_ctl = 4'd12;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_ctl = 4'd2; dec_b = {{16{imm[15]}}, imm}; end
      6'h0A: begin dec_ctl = 4'd7; dec_b = {{16{imm[15]}}, imm}; end
      6'h0C: begin dec_ctl = 4'd0; dec_b = {16'h0000, imm}; end
      6'h0D: begin dec_ctl = 4'd1; dec_b = {16'h0000, imm}; end
      6'h04: begin dec_ctl = 4'd6; dec_beq = 1'b1; end
      6'h05: begin dec_ctl = 4'd6; dec_bne = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_BYPASS_EN
  assign op_ready = (state == IDLE) || ((state == RESP) && res_ready);
`else
  assign op_ready = (state == IDLE);
`endif

  assign accept = op_valid && op_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      br_eq       <= 1'b0;
      br_ne       <= 1'b0;
      alu_ctl     <= 4'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      res_valid   <= 1'b0;
      res_data    <= 32'd0;
      res_taken   <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          if (cnt == 4'd0) begin
            res_data  <= alu_out;
            res_taken <= (br_eq && alu_zero) || (br_ne && !alu_zero);
            res_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase

      // A new op overrides the retire above when both handshakes land together.
      if (accept) begin
        if (dec_legal) begin
          alu_ctl     <= dec_ctl;
          alu_a       <= rs_val;
          alu_b       <= dec_b;
          br_eq       <= dec_beq;
          br_ne       <= dec_bne;
          cnt         <= LAT_M1;
          res_valid   <= 1'b0;
          res_illegal <= 1'b0;
          state       <= EXEC;
        end else begin
          res_valid   <= 1'b1;
          res_illegal <= 1'b1;
          res_data    <= 32'd0;
          res_taken   <= 1'b0;
          state       <= RESP;
        end
      end
    end
  end

endmodule
